// File: rtl/skid_buffer_pkg.sv
// Shared types for the two-entry skid buffer: state encoding, depth, occupancy decode.
// No logic of its own; imported by skid_buffer and sb_reg.
// Backpressure is not applicable at the package level.
package skid_buffer_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    BUSY  = 2'b01,
    FULL  = 2'b10
  } sb_state_t;

  localparam int SB_DEPTH = 2;

  // Unused encodings report as empty; they are left on the next edge anyway.
  function automatic logic [1:0] sb_occupancy(input sb_state_t s);
    case (s)
      BUSY:    sb_occupancy = 2'd1;
      FULL:    sb_occupancy = 2'(SB_DEPTH);
      default: sb_occupancy = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/sb_reg.sv
// Enabled n-bit data register with synchronous active-high clear.
// Latency: q updates one edge after en & d. Backpressure: none, en is the only gate.
module sb_reg
  import skid_buffer_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  logic [N-1:0] data_d;
  logic [N-1:0] data_q;

  always_comb begin
    data_d = data_q;
    if (en) data_d = d;
  end

  always_ff @(posedge clk) begin
    if (reset) data_q <= '0;
    else       data_q <= data_d;
  end

  assign q = data_q;

endmodule

// File: rtl/skid_buffer.sv
// Two-entry elastic stage (main + skid); optional flush port under SKID_BUFFER_FLUSH_EN.
// Latency: 1 cycle, no empty bypass. Backpressure: in_ready is registered-state only,
// it drops once both entries are full and never depends on out_ready.
module skid_buffer
  import skid_buffer_pkg::*;
#(
  parameter int n = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [n-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [n-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
`ifdef SKID_BUFFER_FLUSH_EN
  input  logic         flush,
`endif
  output logic [1:0]   count
);

  sb_state_t    state_d;
  sb_state_t    state_q;
  logic         flush_act;
  logic         in_xfer;
  logic         main_en;
  logic         skid_en;
  logic         main_from_skid;
  logic [n-1:0] main_d;
  logic [n-1:0] main_q;
  logic [n-1:0] skid_q;

`ifdef SKID_BUFFER_FLUSH_EN
  assign flush_act = flush;
`else
  assign flush_act = 1'b0;
`endif

  assign out_valid = (state_q == BUSY) || (state_q == FULL);
  assign in_ready  = ((state_q == EMPTY) || (state_q == BUSY)) && !reset && !flush_act;
  assign out_data  = main_q;
  assign count     = sb_occupancy(state_q);

  always_comb begin
    state_d        = state_q;
    main_en        = 1'b0;
    skid_en        = 1'b0;
    main_from_skid = 1'b0;
    in_xfer        = in_valid && in_ready;
    case (state_q)
      EMPTY: begin
        if (in_xfer) begin
          main_en = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (in_xfer && out_ready) begin
          main_en = 1'b1;
        end else if (in_xfer) begin
          skid_en = 1'b1;
          state_d = FULL;
        end else if (out_ready) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (out_ready) begin
          main_en        = 1'b1;
          main_from_skid = 1'b1;
          state_d        = BUSY;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Flush only forgets occupancy; stored words stay put but become invisible.
    if (flush_act) begin
      state_d = EMPTY;
      main_en = 1'b0;
      skid_en = 1'b0;
    end
  end

  assign main_d = main_from_skid ? skid_q : in_data;

  always_ff @(posedge clk) begin
    if (reset) state_q <= EMPTY;
    else       state_q <= state_d;
  end

  sb_reg #(.N(n)) u_main (
    .clk   (clk),
    .reset (reset),
    .en    (main_en),
    .d     (main_d),
    .q     (main_q)
  );

  sb_reg #(.N(n)) u_skid (
    .clk   (clk),
    .reset (reset),
    .en    (skid_en),
    .d     (in_data),
    .q     (skid_q)
  );

endmodule

// File: tb/tb_skid_buffer.sv
// Bench for skid_buffer: directed vector table, flush sequence (SKID_BUFFER_FLUSH_EN),
// then randomized traffic against a queue model of the buffer.
module tb_skid_buffer;

  logic        clk;
  logic        reset;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        flush;
  logic [1:0]  count;

  int total;
  int bad;

  skid_buffer #(.n(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef SKID_BUFFER_FLUSH_EN
    .flush     (flush),
`endif
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rst;
    logic        iv;
    logic [31:0] id;
    logic        ordy;
    logic        chk;
    logic        e_ov;
    logic [31:0] e_od;
    logic        e_ir;
    logic [1:0]  e_cnt;
  } vec_t;

  function automatic vec_t mk(input logic rst, input logic iv, input logic [31:0] id,
                              input logic ordy, input logic chk, input logic e_ov,
                              input logic [31:0] e_od, input logic e_ir, input logic [1:0] e_cnt);
    vec_t v;
    v.rst = rst; v.iv = iv; v.id = id; v.ordy = ordy; v.chk = chk;
    v.e_ov = e_ov; v.e_od = e_od; v.e_ir = e_ir; v.e_cnt = e_cnt;
    return v;
  endfunction

  // Reference model: the buffer is a FIFO of at most two words.
  logic [31:0] mq[$];

  initial begin
    vec_t        vec[26];
    logic [31:0] next_word;
    logic [31:0] last_got;
    logic        gap;
    logic        prev_stall;
    logic [31:0] prev_data;
    logic        fl;
    logic        exp_ir;
    logic        exp_ov;

    total = 0; bad = 0;
    reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush = 1'b0;

    // Outputs are checked after inputs are applied, before the following edge.
    vec[0]  = mk(1, 1, 32'hDEADBEEF, 0, 0, 0, 0,            0, 0);
    vec[1]  = mk(1, 1, 32'hDEADBEEF, 0, 1, 0, 0,            0, 0);
    vec[2]  = mk(0, 0, 32'h0,        0, 1, 0, 0,            1, 0);
    vec[3]  = mk(0, 1, 32'h1,        1, 1, 0, 0,            1, 0);
    vec[4]  = mk(0, 1, 32'h2,        1, 1, 1, 32'h1,        1, 1);
    vec[5]  = mk(0, 1, 32'h3,        1, 1, 1, 32'h2,        1, 1);
    vec[6]  = mk(0, 1, 32'h4,        1, 1, 1, 32'h3,        1, 1);
    vec[7]  = mk(0, 1, 32'h5,        1, 1, 1, 32'h4,        1, 1);
    vec[8]  = mk(0, 1, 32'h6,        1, 1, 1, 32'h5,        1, 1);
    vec[9]  = mk(0, 1, 32'h7,        1, 1, 1, 32'h6,        1, 1);
    vec[10] = mk(0, 1, 32'h8,        1, 1, 1, 32'h7,        1, 1);
    vec[11] = mk(0, 0, 32'h0,        1, 1, 1, 32'h8,        1, 1);
    vec[12] = mk(0, 0, 32'h0,        1, 1, 0, 0,            1, 0);
    vec[13] = mk(0, 1, 32'hA5A5A5A5, 0, 1, 0, 0,            1, 0);
    vec[14] = mk(0, 1, 32'h5A5A5A5A, 0, 1, 1, 32'hA5A5A5A5, 1, 1);
    vec[15] = mk(0, 1, 32'h12345678, 0, 1, 1, 32'hA5A5A5A5, 0, 2);
    vec[16] = mk(0, 1, 32'h12345678, 0, 1, 1, 32'hA5A5A5A5, 0, 2);
    vec[17] = mk(0, 1, 32'h12345678, 1, 1, 1, 32'hA5A5A5A5, 0, 2);
    vec[18] = mk(0, 1, 32'h12345678, 1, 1, 1, 32'h5A5A5A5A, 1, 1);
    vec[19] = mk(0, 0, 32'h0,        1, 1, 1, 32'h12345678, 1, 1);
    vec[20] = mk(0, 0, 32'h0,        0, 1, 0, 0,            1, 0);
    vec[21] = mk(0, 1, 32'h11111111, 0, 1, 0, 0,            1, 0);
    vec[22] = mk(0, 1, 32'h22222222, 0, 1, 1, 32'h11111111, 1, 1);
    vec[23] = mk(1, 0, 32'h0,        0, 1, 1, 32'h11111111, 0, 2);
    vec[24] = mk(0, 0, 32'h0,        1, 1, 0, 0,            1, 0);
    vec[25] = mk(0, 0, 32'h0,        1, 1, 0, 0,            1, 0);

    for (int i = 0; i < 26; i++) begin
      @(negedge clk);
      reset = vec[i].rst; in_valid = vec[i].iv; in_data = vec[i].id; out_ready = vec[i].ordy;
      #1;
      check($sformatf("v%0d_in_ready", i), {31'b0, in_ready}, {31'b0, vec[i].e_ir});
      if (vec[i].chk) begin
        check($sformatf("v%0d_out_valid", i), {31'b0, out_valid}, {31'b0, vec[i].e_ov});
        check($sformatf("v%0d_count", i), {30'b0, count}, {30'b0, vec[i].e_cnt});
        if (vec[i].e_ov) check($sformatf("v%0d_out_data", i), out_data, vec[i].e_od);
      end
    end

`ifdef SKID_BUFFER_FLUSH_EN
    @(negedge clk); in_valid = 1'b1; in_data = 32'hAAAA0001; out_ready = 1'b0;
    @(negedge clk); in_data = 32'hAAAA0002;
    @(negedge clk); in_data = 32'h33333333; flush = 1'b1;
    #1;
    check("flush_in_ready", {31'b0, in_ready}, 32'd0);
    check("flush_pre_count", {30'b0, count}, 32'd2);
    @(negedge clk); flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    #1;
    check("flush_count", {30'b0, count}, 32'd0);
    check("flush_out_valid", {31'b0, out_valid}, 32'd0);
    @(negedge clk);
    #1;
    check("flush_not_stored", {31'b0, out_valid}, 32'd0);
`endif

    // Randomized traffic; producer holds each word until it is accepted.
    mq.delete();
    next_word = 32'h1000;
    last_got = next_word - 1;
    gap = 1'b0;
    prev_stall = 1'b0;
    prev_data = '0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      reset = 1'b0;
      in_valid = ($urandom_range(0, 3) != 0);
      in_data = next_word;
      out_ready = ($urandom_range(0, 2) != 0);
      fl = 1'b0;
`ifdef SKID_BUFFER_FLUSH_EN
      fl = ($urandom_range(0, 49) == 0);
`endif
      flush = fl;
      #1;
      exp_ir = (mq.size() < 2) && !fl;
      exp_ov = (mq.size() > 0);
      check("rnd_in_ready", {31'b0, in_ready}, {31'b0, exp_ir});
      check("rnd_out_valid", {31'b0, out_valid}, {31'b0, exp_ov});
      check("rnd_count", {30'b0, count}, mq.size());
      if (exp_ov) check("rnd_out_data", out_data, mq[0]);
      if (prev_stall && exp_ov) check("rnd_stable", out_data, prev_data);
      if (exp_ov && out_ready) begin
        if (!gap) check("rnd_order", out_data, last_got + 1);
        last_got = out_data;
        gap = 1'b0;
      end
      prev_stall = exp_ov && !out_ready && !fl;
      prev_data = exp_ov ? mq[0] : '0;
      if (fl) begin
        mq.delete();
        gap = 1'b1;
      end else begin
        if (exp_ov && out_ready) void'(mq.pop_front());
        if (in_valid && exp_ir) begin
          mq.push_back(in_data);
          next_word = next_word + 1;
        end
      end
    end

    @(negedge clk); in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("drain_count", {30'b0, count}, 32'd0);
    check("drain_out_valid", {31'b0, out_valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
